// File: rtl/visitor_center.sv
// -----------------------------------------------------------------------------
// visitor_center
//
// Upstream feeder for the neighborhood calculator array. It holds the body
// table (x, y, mass) that the HPS writes during the fill phase. During a frame
// it broadcasts one "visitor" body at a time to every neighborhood and moves
// to the next visitor on each sweep-complete request. It tells the owning
// neighborhood which of its own bodies is the visitor, so that body can skip
// interacting with itself. It flags end of frame (visitor_done_o) and frame
// completion to the HPS (all_done_o).
//
// Optional build macro: VISITOR_CYCLE_COUNT_EN
//   When defined, adds run_cycles_o. This counter is cleared on FILL->RUN and
//   counts the cycles spent in RUN and DRAIN, for frame timing on the HPS.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   filling_i               HPS fill phase (shared with the neighborhoods)
//   wr_we_i, wr_addr_i      body table write port
//   wr_x_i/wr_y_i/wr_mass_i body data written to the table
//   total_max_i             index of the last body (N-1)
//   per_town_max_i          last per-town body index
//   next_i                  advance request from neighborhood 0
//   town_done_i             done flag from each neighborhood
//   visitor_*_o             broadcast visitor body
//   relative_visitor_*_o    owning town (one-hot) and index inside that town
//   visitor_done_o          last visitor has been retired
//   all_done_o              frame complete
// -----------------------------------------------------------------------------
module visitor_center #(
    parameter int NUM_TOWNS     = 4,
    parameter int TOWN_ADDR_LEN = 12,
    parameter int VIS_DEPTH     = 16384,
    parameter int VIS_ADDR_LEN  = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     filling_i,
    input  logic                     wr_we_i,
    input  logic [VIS_ADDR_LEN-1:0]  wr_addr_i,
    input  logic [31:0]              wr_x_i,
    input  logic [31:0]              wr_y_i,
    input  logic [31:0]              wr_mass_i,
    input  logic [VIS_ADDR_LEN-1:0]  total_max_i,
    input  logic [TOWN_ADDR_LEN-1:0] per_town_max_i,
    input  logic                     next_i,
    input  logic [NUM_TOWNS-1:0]     town_done_i,
    output logic [31:0]              visitor_x_pos_o,
    output logic [31:0]              visitor_y_pos_o,
    output logic [31:0]              visitor_mass_o,
    output logic [NUM_TOWNS-1:0]     relative_visitor_valid_o,
    output logic [TOWN_ADDR_LEN-1:0] relative_visitor_index_o,
    output logic                     visitor_done_o,
    output logic                     all_done_o
`ifdef VISITOR_CYCLE_COUNT_EN
    ,
    output logic [31:0]              run_cycles_o
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [VIS_ADDR_LEN-1:0]  VIS_ONE   = VIS_ADDR_LEN'(1);
    localparam logic [VIS_ADDR_LEN-1:0]  VIS_TWO   = VIS_ADDR_LEN'(2);
    localparam logic [TOWN_ADDR_LEN-1:0] TOWN_ONE  = TOWN_ADDR_LEN'(1);
    localparam logic [NUM_TOWNS-1:0]     SEL_FIRST = NUM_TOWNS'(1);

    // Body table: one RAM per field
    logic [31:0] mem_x [VIS_DEPTH];
    logic [31:0] mem_y [VIS_DEPTH];
    logic [31:0] mem_m [VIS_DEPTH];

    state_t                   state_q, state_d;
    logic [31:0]              cur_x_q, cur_x_d, cur_y_q, cur_y_d, cur_m_q, cur_m_d;
    logic [VIS_ADDR_LEN-1:0]  cur_idx_q, cur_idx_d;
    logic [31:0]              pre_x_q, pre_x_d, pre_y_q, pre_y_d, pre_m_q, pre_m_d;
    logic [TOWN_ADDR_LEN-1:0] rel_idx_q, rel_idx_d;
    logic [NUM_TOWNS-1:0]     town_sel_q, town_sel_d;
    logic [NUM_TOWNS-1:0]     seen_q, seen_d;
    logic                     vdone_q, vdone_d, adone_q, adone_d;
    logic [VIS_ADDR_LEN-1:0]  rd_addr_q, rd_addr_d;
    logic [31:0]              rd_x_q, rd_y_q, rd_m_q;
    logic                     ld1_q, ld1_d, ld2_q;
    logic                     fill_wr_s;
`ifdef VISITOR_CYCLE_COUNT_EN
    logic [31:0]              cycles_q, cycles_d;
`endif

    // HPS write port of the body table (contents are not reset)
    always_ff @(posedge clk) begin
        if (wr_we_i) begin
            mem_x[wr_addr_i] <= wr_x_i;
            mem_y[wr_addr_i] <= wr_y_i;
            mem_m[wr_addr_i] <= wr_mass_i;
        end
    end

    // Internal read port: registered address in, registered data out
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_x_q <= 32'd0;
            rd_y_q <= 32'd0;
            rd_m_q <= 32'd0;
            ld2_q  <= 1'b0;
        end else begin
            rd_x_q <= mem_x[rd_addr_q];
            rd_y_q <= mem_y[rd_addr_q];
            rd_m_q <= mem_m[rd_addr_q];
            // Follows the read pipeline, so the prefetch lands in pre two cycles after it is issued
            ld2_q  <= ld1_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_x_q    <= 32'd0;
            cur_y_q    <= 32'd0;
            cur_m_q    <= 32'd0;
            cur_idx_q  <= '0;
            pre_x_q    <= 32'd0;
            pre_y_q    <= 32'd0;
            pre_m_q    <= 32'd0;
            rel_idx_q  <= '0;
            town_sel_q <= '0;
            seen_q     <= '0;
            vdone_q    <= 1'b0;
            adone_q    <= 1'b0;
            rd_addr_q  <= '0;
            ld1_q      <= 1'b0;
`ifdef VISITOR_CYCLE_COUNT_EN
            cycles_q   <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            cur_m_q    <= cur_m_d;
            cur_idx_q  <= cur_idx_d;
            pre_x_q    <= pre_x_d;
            pre_y_q    <= pre_y_d;
            pre_m_q    <= pre_m_d;
            rel_idx_q  <= rel_idx_d;
            town_sel_q <= town_sel_d;
            seen_q     <= seen_d;
            vdone_q    <= vdone_d;
            adone_q    <= adone_d;
            rd_addr_q  <= rd_addr_d;
            ld1_q      <= ld1_d;
`ifdef VISITOR_CYCLE_COUNT_EN
            cycles_q   <= cycles_d;
`endif
        end
    end

    assign fill_wr_s = (state_q == FILL) && wr_we_i;

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        cur_m_d    = cur_m_q;
        cur_idx_d  = cur_idx_q;
        rel_idx_d  = rel_idx_q;
        town_sel_d = town_sel_q;
        seen_d     = seen_q;
        vdone_d    = vdone_q;
        adone_d    = adone_q;
        rd_addr_d  = rd_addr_q;
        ld1_d      = 1'b0;
        pre_x_d    = pre_x_q;
        pre_y_d    = pre_y_q;
        pre_m_d    = pre_m_q;
        if (ld2_q) begin
            pre_x_d = rd_x_q;
            pre_y_d = rd_y_q;
            pre_m_d = rd_m_q;
        end else begin
            pre_m_d = pre_m_q;
        end
`ifdef VISITOR_CYCLE_COUNT_EN
        if ((state_q == RUN) || (state_q == DRAIN)) begin
            cycles_d = cycles_q + 32'd1;
        end else begin
            cycles_d = cycles_q;
        end
`endif

        case (state_q)
            IDLE: begin
                if (filling_i) begin
                    state_d = FILL;
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                // Bodies 0 and 1 are captured as they are written, so visitor 0 is
                // stable when calc starts and body 1 is already staged in pre
                if (fill_wr_s && (wr_addr_i == '0)) begin
                    cur_x_d = wr_x_i;
                    cur_y_d = wr_y_i;
                    cur_m_d = wr_mass_i;
                end else if (fill_wr_s && (wr_addr_i == VIS_ONE)) begin
                    pre_x_d = wr_x_i;
                    pre_y_d = wr_y_i;
                    pre_m_d = wr_mass_i;
                end else begin
                    cur_m_d = cur_m_q;
                end
                if (!filling_i) begin
                    cur_idx_d  = '0;
                    rel_idx_d  = '0;
                    town_sel_d = SEL_FIRST;
                    rd_addr_d  = VIS_TWO;
                    state_d    = RUN;
`ifdef VISITOR_CYCLE_COUNT_EN
                    cycles_d   = 32'd0;
`endif
                end else begin
                    state_d = FILL;
                end
            end
            RUN: begin
                if (next_i && (cur_idx_q == total_max_i)) begin
                    cur_m_d    = 32'd0;
                    vdone_d    = 1'b1;
                    town_sel_d = '0;
                    seen_d     = '0;
                    state_d    = DRAIN;
                end else if (next_i) begin
                    cur_x_d   = pre_x_q;
                    cur_y_d   = pre_y_q;
                    cur_m_d   = pre_m_q;
                    cur_idx_d = cur_idx_q + VIS_ONE;
                    if (rel_idx_q == per_town_max_i) begin
                        rel_idx_d  = '0;
                        town_sel_d = (town_sel_q << 1) | (town_sel_q >> (NUM_TOWNS - 1));
                    end else begin
                        rel_idx_d = rel_idx_q + TOWN_ONE;
                    end
                    // Fetch two ahead of the retiring visitor; lands in pre before the next request
                    rd_addr_d = cur_idx_q + VIS_TWO;
                    ld1_d     = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                seen_d = seen_q | town_done_i;
                if (&seen_d) begin
                    vdone_d = 1'b0;
                    adone_d = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                if (filling_i) begin
                    adone_d = 1'b0;
                    state_d = FILL;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign visitor_x_pos_o          = cur_x_q;
    assign visitor_y_pos_o          = cur_y_q;
    assign visitor_mass_o           = cur_m_q;
    assign relative_visitor_valid_o = town_sel_q;
    assign relative_visitor_index_o = rel_idx_q;
    assign visitor_done_o           = vdone_q;
    assign all_done_o               = adone_q;
`ifdef VISITOR_CYCLE_COUNT_EN
    assign run_cycles_o             = cycles_q;
`endif

endmodule

// File: doc/visitor_center.md
Name: visitor_center

Overview:
- Upstream feeder for the array of neighborhood calculators.
- Holds the full-frame body table (x, y, mass) written by the HPS and broadcasts one "visitor" body at a time to every neighborhood.
- Advances to the next visitor each time the neighborhoods finish a sweep.
- Tells the owning neighborhood which of its bodies is the visitor (self-interaction suppression), signals end-of-frame with visitor_done, and reports completion to the HPS.

Parameters:
- NUM_TOWNS, 4, number of neighborhoods fed.
- TOWN_ADDR_LEN, 12, width of per-neighborhood body index.
- VIS_DEPTH, 16384, body table depth.
- VIS_ADDR_LEN, 14, width of body table address.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- filling  in  1  HPS fill phase; same signal the neighborhoods receive
- wr_we  in  1  body table write enable
- wr_addr  in  VIS_ADDR_LEN  body table write address
- wr_x  in  32  x position data
- wr_y  in  32  y position data
- wr_mass  in  32  mass data
- total_max  in  VIS_ADDR_LEN  index of last body (N-1)
- per_town_max  in  TOWN_ADDR_LEN  last per-town index; the same max_index the neighborhoods receive
- next  in  1  advance request from neighborhood 0
- town_done  in  NUM_TOWNS  done from each neighborhood
- visitor_x_pos  out  32  broadcast visitor x
- visitor_y_pos  out  32  broadcast visitor y
- visitor_mass  out  32  broadcast visitor mass
- relative_visitor_valid  out  NUM_TOWNS  one-hot; selects the town owning the visitor
- relative_visitor_index  out  TOWN_ADDR_LEN  visitor index within the owning town
- visitor_done  out  1  last visitor has been retired
- all_done  out  1  frame complete, to HPS

Behaviour:
- Reset values: state IDLE; all outputs 0. Reset mid-frame aborts to IDLE the next cycle, with visitor_done and all_done low.
- Body table: three 32-bit dual-port RAMs.
  - Port B: HPS write.
  - Port A: internal read, 2-cycle latency (registered address, registered output).
- Registers:
  - cur: x, y, mass, idx.
  - pre: x, y, mass, the prefetched next body.
  - rel_idx and town_sel drive relative_visitor_index and relative_visitor_valid.
- States: IDLE, FILL, RUN, DRAIN, DONE.
- IDLE: filling=1 -> FILL.
- FILL:
  - A write with wr_we=1 to wr_addr=0 also loads cur (x, y, mass). A write to wr_addr=1 also loads pre. Writes to other addresses touch only the table.
  - A write in any state other than FILL touches only the table.
  - When filling falls: cur.idx=0, rel_idx=0, town_sel=1 (bit 0), read address := 2 issued -> RUN. The neighborhoods enter calc on the same edge and see visitor 0 already stable.
- RUN, on each cycle with next=1:
  - If cur.idx == total_max: visitor_mass <= 0 (x/y held), visitor_done <= 1, relative_visitor_valid <= 0 -> DRAIN.
  - Otherwise:
    - cur <= pre; cur.idx++.
    - rel_idx wraps to 0 when it equals per_town_max, and town_sel rotates left one bit; otherwise rel_idx++.
    - Issue read of cur.idx+2. Its data loads pre 2 cycles later.
    - New visitor outputs are valid the cycle after next.
  - Read addresses beyond total_max are issued but the data is unused.
- Prefetch constraint: per_town_max >= 3, so next arrives at least 4 cycles apart. Behaviour with smaller values is undefined.
- Single-body case: total_max=0 -> first next goes straight to DRAIN.
- DRAIN: visitor_done held high. When all town_done bits have been seen high (sticky per-bit capture, cleared on entry), visitor_done <= 0, all_done <= 1 -> DONE.
- DONE: all_done held high; filling=1 -> all_done <= 0 -> FILL.
- next outside RUN is ignored.
- town_done bits arriving in different cycles are accumulated.

Optional Feature:
- Macro: VISITOR_CYCLE_COUNT_EN.
- Defined:
  - Adds output run_cycles (32-bit), cleared on FILL->RUN.
  - Increments every cycle in RUN or DRAIN; holds in DONE; reset value 0. Used for HPS frame timing.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Fill/prefetch: fill 8 bodies with mass=idx+1, per_town_max=3, NUM_TOWNS=2, total_max=7; drop filling.
  -> Same cycle: visitor_mass=1, relative_visitor_valid=01, relative_visitor_index=0.
- Advance sequence: pulse next every 4 cycles.
  -> visitor_mass = 2,3,4,5 …, each change one cycle after next.
  -> relative index: 1,2,3, then 0 with valid=10 at body 4.
- Last visitor: next while idx=7.
  -> visitor_mass=0, visitor_done=1, valid=00.
  -> town_done=01 then 10 on later cycles -> all_done=1 one cycle after second bit; visitor_done=0.
- Single body: total_max=0; fill; first next -> DRAIN immediately with visitor_mass=0.
- Reset mid-RUN: assert reset at body 3.
  -> Next cycle all outputs 0, state IDLE; a later fill/run restarts at body 0.
- VISITOR_CYCLE_COUNT_EN: 8-body run with next every 4 cycles and town_done 5 cycles after the last next.
  -> run_cycles = cycles in RUN+DRAIN (36), holds in DONE.
